// File: rtl/fsm_counter_param.sv
// Parametrised mode-selectable counter FSM: up-wrap, down-wrap, bounce and one-shot modes,
// with load, enable and tc/done flags. Define FSM_COUNTER_GRAY_EN to add a registered gray_count output.
module fsm_counter_param #(
    parameter int WIDTH   = 3,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             done
`ifdef FSM_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray_count
`endif
);

    typedef enum logic [1:0] {S_UP = 2'b00, S_DOWN = 2'b01, S_HALT = 2'b10} state_e;
    typedef enum logic [1:0] {M_UP = 2'b00, M_DOWN = 2'b01, M_BOUNCE = 2'b10, M_ONESHOT = 2'b11} mode_e;

    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_P1 = WIDTH'(MIN_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX_VAL - 1);

    generate
        if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 2**WIDTH - 1) begin : g_bad_params
            $error("fsm_counter_param: require 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
        end
    endgenerate

    state_e           state_q, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic             cnt_above, cnt_below, ld_above, ld_below;
    logic [WIDTH-1:0] load_clamped;

    // Bound comparisons only exist when the bound lies inside the WIDTH-bit range.
    generate
        if (MAX_VAL < 2**WIDTH - 1) begin : g_hi_chk
            assign cnt_above = (count_q > MAX_W);
            assign ld_above  = (load_val > MAX_W);
        end else begin : g_hi_none
            assign cnt_above = 1'b0;
            assign ld_above  = 1'b0;
        end
        if (MIN_VAL > 0) begin : g_lo_chk
            assign cnt_below = (count_q < MIN_W);
            assign ld_below  = (load_val < MIN_W);
        end else begin : g_lo_none
            assign cnt_below = 1'b0;
            assign ld_below  = 1'b0;
        end
    endgenerate

    assign load_clamped = ld_above ? MAX_W : (ld_below ? MIN_W : load_val);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_n = state_q;
        count_n = count_q;
        if (load) begin
            count_n = load_clamped;
            state_n = (mode_e'(mode) == M_DOWN) ? S_DOWN : S_UP;
        end else if (en) begin
            if (cnt_above || cnt_below) begin
                count_n = MIN_W;
                state_n = S_UP;
            end else begin
                case (state_q)
                    S_HALT: ;
                    S_UP, S_DOWN: begin
                        case (mode_e'(mode))
                            M_UP: begin
                                state_n = S_UP;
                                count_n = (count_q == MAX_W) ? MIN_W : count_q + WIDTH'(1);
                            end
                            M_DOWN: begin
                                state_n = S_DOWN;
                                count_n = (count_q == MIN_W) ? MAX_W : count_q - WIDTH'(1);
                            end
                            M_BOUNCE: begin
                                if (state_q == S_UP) begin
                                    if (count_q == MAX_W) begin
                                        state_n = S_DOWN;
                                        count_n = MAX_M1;
                                    end else begin
                                        count_n = count_q + WIDTH'(1);
                                    end
                                end else if (count_q == MIN_W) begin
                                    state_n = S_UP;
                                    count_n = MIN_P1;
                                end else begin
                                    count_n = count_q - WIDTH'(1);
                                end
                            end
                            default: begin
                                // One-shot: halt on the step that lands on MAX_VAL.
                                if (count_q != MAX_W) begin
                                    count_n = count_q + WIDTH'(1);
                                end
                                state_n = (count_n == MAX_W) ? S_HALT : S_UP;
                            end
                        endcase
                    end
                    default: begin
                        count_n = MIN_W;
                        state_n = S_UP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all state updates together at the edge.
        if (rst) begin
            state_q <= S_UP;
            count_q <= MIN_W;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
        end
    end

`ifdef FSM_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q;

    // Encoded from count_n so the Gray value is aligned with count on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= MIN_W ^ (MIN_W >> 1);
        end else begin
            gray_q <= count_n ^ (count_n >> 1);
        end
    end

    assign gray_count = gray_q;
`endif

    assign count = count_q;
    assign dir   = (state_q != S_DOWN);
    assign done  = (state_q == S_HALT);
    assign tc    = dir ? (count_q == MAX_W) : (count_q == MIN_W);

endmodule

// File: tb/tb_fsm_counter_param.sv
// Directed bench for fsm_counter_param: default 3-bit instance plus a WIDTH=4, MIN=2, MAX=8
// instance for clamping and non-zero lower bound.
module tb_fsm_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, load;
    logic [1:0] mode;
    logic [2:0] load_val;
    logic [2:0] count;
    logic       dir, tc, done;

    logic       rst_b, en_b, load_b;
    logic [1:0] mode_b;
    logic [3:0] load_val_b;
    logic [3:0] count_b;
    logic       dir_b, tc_b, done_b;

`ifdef FSM_COUNTER_GRAY_EN
    logic [2:0] gray_count;
    logic [3:0] gray_count_b;
`endif

    int total = 0;
    int bad   = 0;

    fsm_counter_param #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(7)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .count(count), .dir(dir), .tc(tc), .done(done)
`ifdef FSM_COUNTER_GRAY_EN
        , .gray_count(gray_count)
`endif
    );

    fsm_counter_param #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(8)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .load(load_b), .load_val(load_val_b),
        .count(count_b), .dir(dir_b), .tc(tc_b), .done(done_b)
`ifdef FSM_COUNTER_GRAY_EN
        , .gray_count(gray_count_b)
`endif
    );

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
`ifdef FSM_COUNTER_GRAY_EN
        total++;
        if (gray_count !== (count ^ (count >> 1))) begin
            bad++;
            $display("FAIL gray_a: got %b want %b", gray_count, count ^ (count >> 1));
        end
        total++;
        if (gray_count_b !== (count_b ^ (count_b >> 1))) begin
            bad++;
            $display("FAIL gray_b: got %b want %b", gray_count_b, count_b ^ (count_b >> 1));
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; load_val = 3'd0;
        tick();
        tick();
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++;
        if (dir !== 1'b1) begin bad++; $display("FAIL reset_dir: got %b want 1", dir); end
        total++;
        if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %b want 0", tc); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_up();
        logic [2:0] exp_c [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        rst = 1'b0; en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (count !== exp_c[i] || tc !== (exp_c[i] == 3'd7) || dir !== 1'b1) begin
                bad++;
                $display("FAIL up[%0d]: got c=%0d tc=%b dir=%b want c=%0d tc=%b dir=1",
                         i, count, tc, dir, exp_c[i], exp_c[i] == 3'd7);
            end
        end
    endtask

    task automatic test_down();
        logic [2:0] exp_c [4] = '{3'd1, 3'd0, 3'd7, 3'd6};
        mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (count !== exp_c[i] || tc !== (exp_c[i] == 3'd0) || dir !== 1'b0) begin
                bad++;
                $display("FAIL down[%0d]: got c=%0d tc=%b dir=%b want c=%0d tc=%b dir=0",
                         i, count, tc, dir, exp_c[i], exp_c[i] == 3'd0);
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] exp_c [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                   3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
        logic       exp_d [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_tc;
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; mode = 2'b10;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_tc = (i == 6) || (i == 13);
            total++;
            if (count !== exp_c[i] || dir !== exp_d[i] || tc !== exp_tc) begin
                bad++;
                $display("FAIL bounce[%0d]: got c=%0d dir=%b tc=%b want c=%0d dir=%b tc=%b",
                         i, count, dir, tc, exp_c[i], exp_d[i], exp_tc);
            end
        end
    endtask

    task automatic test_oneshot();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; mode = 2'b11;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (count !== 3'(i + 1) || done !== (i == 6)) begin
                bad++;
                $display("FAIL oneshot_run[%0d]: got c=%0d done=%b want c=%0d done=%b",
                         i, count, done, i + 1, i == 6);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (count !== 3'd7 || done !== 1'b1 || tc !== 1'b1) begin
                bad++;
                $display("FAIL oneshot_hold[%0d]: got c=%0d done=%b tc=%b want c=7 done=1 tc=1",
                         i, count, done, tc);
            end
        end
        load = 1'b1; load_val = 3'd3;
        tick();
        load = 1'b0;
        total++;
        if (count !== 3'd3 || done !== 1'b0 || dir !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_load: got c=%0d done=%b dir=%b want c=3 done=0 dir=1",
                     count, done, dir);
        end
    endtask

    task automatic test_hold();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (count !== 3'd5) begin bad++; $display("FAIL hold_pre: got %0d want 5", count); end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode = 2'(i);
            tick();
            total++;
            if (count !== 3'd5 || dir !== 1'b1) begin
                bad++;
                $display("FAIL hold[%0d]: got c=%0d dir=%b want c=5 dir=1", i, count, dir);
            end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; mode = 2'b11;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL b2b_halt: got done=%b want 1", done); end
        for (int i = 0; i < 3; i++) begin
            mode = 2'(i);
            tick();
            total++;
            if (count !== 3'd7 || done !== 1'b1) begin
                bad++;
                $display("FAIL b2b_mode[%0d]: got c=%0d done=%b want c=7 done=1", i, count, done);
            end
        end
        rst = 1'b1; load = 1'b1; load_val = 3'd5;
        tick();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        total++;
        if (count !== 3'd0 || done !== 1'b0 || dir !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rst_halt: got c=%0d done=%b dir=%b want c=0 done=0 dir=1",
                     count, done, dir);
        end
    endtask

    task automatic test_load_clamp();
        rst_b = 1'b1; en_b = 1'b0; load_b = 1'b0; mode_b = 2'b00; load_val_b = 4'd0;
        tick();
        tick();
        total++;
        if (count_b !== 4'd2 || tc_b !== 1'b0) begin
            bad++;
            $display("FAIL clamp_reset: got c=%0d tc=%b want c=2 tc=0", count_b, tc_b);
        end
        rst_b = 1'b0; load_b = 1'b1; load_val_b = 4'd9;
        tick();
        total++;
        if (count_b !== 4'd8 || tc_b !== 1'b1) begin
            bad++;
            $display("FAIL clamp_hi: got c=%0d tc=%b want c=8 tc=1", count_b, tc_b);
        end
        load_val_b = 4'd0;
        tick();
        total++;
        if (count_b !== 4'd2) begin bad++; $display("FAIL clamp_lo: got %0d want 2", count_b); end
        load_val_b = 4'd5;
        tick();
        total++;
        if (count_b !== 4'd5) begin bad++; $display("FAIL clamp_mid: got %0d want 5", count_b); end
        rst_b = 1'b1; load_val_b = 4'd9;
        tick();
        total++;
        if (count_b !== 4'd2) begin bad++; $display("FAIL clamp_rst_wins: got %0d want 2", count_b); end
        rst_b = 1'b0;
        tick();
        load_b = 1'b0; en_b = 1'b1; mode_b = 2'b00;
        tick();
        total++;
        if (count_b !== 4'd2) begin bad++; $display("FAIL b_wrap_up: got %0d want 2", count_b); end
        mode_b = 2'b01;
        tick();
        total++;
        if (count_b !== 4'd8 || dir_b !== 1'b0 || tc_b !== 1'b0) begin
            bad++;
            $display("FAIL b_wrap_down: got c=%0d dir=%b tc=%b want c=8 dir=0 tc=0",
                     count_b, dir_b, tc_b);
        end
        tick();
        total++;
        if (count_b !== 4'd7) begin bad++; $display("FAIL b_down_step: got %0d want 7", count_b); end
        en_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; load_val = 3'd0;
        rst_b = 1'b1; en_b = 1'b0; load_b = 1'b0; mode_b = 2'b00; load_val_b = 4'd0;
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_oneshot();
        test_hold();
        test_back_to_back();
        test_load_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
